// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmitter state encoding and the line levels that the
// transmitter and the receiver must agree on.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Line level while nothing is being sent, and level of the start bit.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_if.sv
// FIFO read port as seen by the UART transmitter.
//   fifo_data  : head entry of the FIFO, valid whenever fifo_empty is low
//   fifo_empty : high when the FIFO holds no entry
//   fifo_read  : single-cycle pop request
// Handshake: the head entry is offered while fifo_empty=0 (the "valid");
// the consumer takes it by raising fifo_read for one clk, and the entry is
// consumed on that same rising edge. fifo_read is only ever raised while
// fifo_empty=0, and fifo_data may change freely after the pop edge.
interface uart_tx_if #(
  parameter int DATA_SIZE = 8
);
  import uart_pkg::*;

  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_empty;
  logic                 fifo_read;

  // master: the transmitter, which pops entries
  modport master (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read
  );

  // slave: the FIFO, which offers entries
  modport slave (
    output fifo_data,
    output fifo_empty,
    input  fifo_read
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmit serializer.
// Pops one byte from the TX FIFO, then sends start bit, DATA_SIZE data bits
// LSB first, an optional parity bit and 1 or 2 stop bits. Bit timing is
// OVERSAMPLE pulses of the external baud_tick per bit.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   baud_tick               : one-cycle enable at OVERSAMPLE x baud rate
//   fifo_if (master)        : fifo_data / fifo_empty in, fifo_read out
//   parity_en, parity_odd   : parity enable and odd/even select
//   stop2                   : 1 = two stop bits
//   tx                      : serial line, idles high, registered
//   busy                    : high from the cycle after the pop until one
//                             cycle after the last stop bit
//   state_dbg               : current FSM state for observation
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_W     = $clog2(OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  uart_tx_if.master  fifo_if,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop2,
  output logic       tx,
  output logic       busy,
  output tx_state_t  state_dbg
);

  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

  tx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0] shift_q, shift_d;
  logic [DATA_SIZE-1:0] data_q, data_d;      // untouched copy for parity
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic pop;
  logic bit_end;

  // busy_q still high in IDLE marks the one mandatory idle cycle after a
  // frame, so no pop is taken there. Reset also blocks the pop so the FIFO
  // is not drained while the transmitter is held in reset.
  assign pop     = reset_n && (state_q == IDLE) && !busy_q && !fifo_if.fifo_empty;
  assign bit_end = (state_q != IDLE) && baud_tick && (tick_cnt_q == TICK_LAST);

  assign fifo_if.fifo_read = pop;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    busy_d     = busy_q;
    tx_d       = UART_IDLE_LEVEL;

    if (state_q == IDLE) begin
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pop) begin
          shift_d   = fifo_if.fifo_data;
          data_d    = fifo_if.fifo_data;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          stop2_d   = stop2;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is derived from the next state so tx is registered and
    // only moves on state or bit transitions.
    case (state_d)
      START:   tx_d = UART_START_LEVEL;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = (^data_d) ^ par_odd_d;
      default: tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer. It pops bytes from the TX-side uart_fifo through that FIFO's read/empty/data_out interface and drives the serial line. Each frame is: start bit, DATA_SIZE data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing comes from an external oversampling baud tick shared with the receiver path.

Parameters:
DATA_SIZE, 8, data bits per frame; must match the FIFO's DATA_SIZE.
OVERSAMPLE, 16, baud_tick pulses per bit period; must be 2 or more.
TICK_W, $clog2(OVERSAMPLE), tick counter width.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active-low
baud_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate
fifo_data  input  DATA_SIZE  FIFO data_out (head entry, combinational)
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  pop pulse to FIFO read
parity_en  input  1  1 = insert parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
stop2  input  1  1 = two stop bits, 0 = one stop bit
tx  output  1  serial line; idles high
busy  output  1  high from the pop cycle until the last stop bit ends

Behaviour:
- Reset (async, any state including mid-frame): tx=1, busy=0, fifo_read=0, state=IDLE, counters=0, shift register=0. A truncated frame is not resumed; the FIFO entry already popped is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - If fifo_empty=0: assert fifo_read for exactly one clk, load fifo_data into the shift register in the same edge, and latch parity_en/parity_odd/stop2 into the frame config.
  - Go to START, with busy=1 and tx=0 from the next cycle.
  - fifo_read is never asserted while fifo_empty=1 or outside IDLE.
- Bit timing:
  - tick_cnt increments only on baud_tick.
  - A bit ends on the clk where baud_tick=1 and tick_cnt=OVERSAMPLE-1; tick_cnt then wraps to 0 and the state or bit advances.
  - Every bit therefore lasts exactly OVERSAMPLE ticks. Ticks arriving in IDLE are ignored, and tick_cnt is held at 0 there.
- START: tx=0; after one bit period go to DATA with bit_cnt=0.
- DATA:
  - tx = shift register bit 0; shift right at each bit end.
  - After bit_cnt=DATA_SIZE-1, go to PARITY if the latched parity_en=1, otherwise STOP.
- PARITY:
  - tx = XOR of the latched data word, inverted when the latched parity_odd=1.
  - The parity value is computed from a copy of the data held separately from the shift register.
  - After one bit period go to STOP.
- STOP:
  - tx=1 for 1 bit period, or 2 if the latched stop2=1.
  - At the end go to IDLE and drop busy on the following cycle.
- Back-to-back frames: IDLE lasts at least 1 clk between frames, so the idle-high gap is 1 clk plus the pop cycle. There are no extra bit periods between frames.
- Config inputs changing mid-frame have no effect until the next pop.
- fifo_data is sampled only in the pop cycle; the FIFO head may change afterwards.
- tx is a registered output with no glitches. It changes only on state or bit transitions.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants UART_IDLE_LEVEL=1'b1 and UART_START_LEVEL=1'b0, shared with the receiver.
- No sub-module. The baud tick generator is external and shared. Integration pairs uart_fifo (read/empty/data_out) with uart_tx (fifo_read/fifo_empty/fifo_data).

Test Plan:
- Reset: hold reset_n=0 -> tx=1, busy=0, fifo_read=0; FIFO empty after release -> tx stays 1 for 1000 clks and fifo_read never pulses.
- Single 8N1 byte: baud_tick=1 every clk, OVERSAMPLE=16, push 0xA5 -> one fifo_read pulse; tx low for 16 clks; data bits 1,0,1,0,0,1,0,1, 16 clks each; tx high 16 clks; busy high for 161 clks total.
- Parity: 0xA5 (four ones) with parity_en=1 -> even parity bit 0, odd parity bit 1. Then 0x07 with even parity -> parity bit 1.
- Two stop bits with baud_tick every 4th clk: stop2=1, byte 0x3C -> stop phase lasts 32 ticks = 128 clks; total frame is 11 bit periods.
- Back-to-back: push 0x55, 0xAA, 0xFF together -> exactly 3 fifo_read pulses, in order, each only in IDLE; serial decodes 0x55, 0xAA, 0xFF; gap between frames is 2 clks; no fifo_read while empty.
- Mid-frame reset, config change and tick gating: pull reset_n low during DATA bit 3 -> tx=1 immediately and no further pops until release. Toggle parity_en mid-frame -> current frame is unchanged. Hold baud_tick=0 in DATA for 50 clks -> tx and the state are frozen.
